// File: rtl/t5_pkg.sv
// Shared constants and types for the hart scheduler / GPR sequencer.
package t5_pkg;
  localparam int NHART     = 4;
  localparam int HART_W    = 2;
  localparam int REG_W     = 5;
  localparam int GPR_DEPTH = 128;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  // One pipeline slot: which hart owns it and whether it carries work.
  typedef struct packed {
    logic [HART_W-1:0] hart;
    logic              vld;
  } slot_t;
endpackage

// File: rtl/t5_rrarb.sv
// 4-way round-robin find-first: search last+1, last+2, last+3, last.
module t5_rrarb
  import t5_pkg::*;
(
  input  logic [NHART-1:0]  req,
  input  logic [HART_W-1:0] last,
  output logic [HART_W-1:0] gnt_id,
  output logic              gnt_vld
);

  logic [HART_W-1:0] idx;

  // Walk the search order backwards so the nearest candidate after last wins.
  always_comb begin
    gnt_id  = last;
    gnt_vld = 1'b0;
    idx     = last;
    for (int k = NHART; k >= 1; k--) begin
      idx = last + HART_W'(k);
      if (req[idx]) begin
        gnt_id  = idx;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/t5_hsched.sv
// Hart scheduler and GPR sequencer for the 4-hart barrel pipeline.
// Clears the register file after reset, then issues one eligible hart per
// cycle round-robin and carries the hart ID down F/D/E/M.
module t5_hsched
  import t5_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              sclk,
  input  logic              srstn,
  input  logic [NHART-1:0]  hena,
  input  logic [NHART-1:0]  wak,
  input  logic              slp_req,
  input  logic              wb_wre,
  input  logic [REG_W-1:0]  wb_rda,
  input  logic [XLEN-1:0]   wb_dat,
  output logic              rdy,
  output logic [HART_W-1:0] fhart,
  output logic              fvld,
  output logic [HART_W-1:0] dhart,
  output logic [HART_W-1:0] ehart,
  output logic              evld,
  output logic [HART_W-1:0] mhart,
  output logic              mvld,
  output logic [REG_W-1:0]  rd0a,
  output logic [XLEN-1:0]   rd0d,
  output logic              mwre
);

  state_t            state;
  logic [6:0]        cnt;
  logic [NHART-1:0]  awake;
  logic [HART_W-1:0] last;
  logic [HART_W-1:0] fhart_hold;
  slot_t             d_q, e_q, m_q;

  logic [NHART-1:0]  elig;
  logic [HART_W-1:0] gnt_id;
  logic              gnt_vld;
  logic              sleep;
  logic [NHART-1:0]  sleep_mask;

  // Nothing is eligible while the register file is still being cleared.
  assign elig = (state == RUN) ? (hena & awake) : '0;

  t5_rrarb u_arb (
    .req     (elig),
    .last    (last),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  assign fvld  = gnt_vld;
  assign fhart = gnt_vld ? gnt_id : fhart_hold;

  // A sleep request is only meaningful when the E slot carries work.
  assign sleep      = slp_req & e_q.vld;
  assign sleep_mask = sleep ? (NHART'(1) << e_q.hart) : '0;

  assign rdy   = (state == RUN);
  assign dhart = d_q.hart;
  assign ehart = e_q.hart;
  assign evld  = e_q.vld;
  assign mvld  = m_q.vld;

  // INIT/RUN sequencing; cnt walks every GPR entry once after reset.
  always_ff @(posedge sclk or negedge srstn) begin
    if (!srstn) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + 7'd1;
          if (cnt == 7'(GPR_DEPTH - 1)) state <= RUN;
        end
        RUN:     state <= RUN;
        default: state <= INIT;
      endcase
    end
  end

  // Awake bits: a wake in the same cycle as a sleep to that hart wins.
  always_ff @(posedge sclk or negedge srstn) begin
    if (!srstn) awake <= 4'b0001;
    else        awake <= (awake & ~sleep_mask) | wak;
  end

  // Round-robin pointer and held fetch ID advance only on an issue.
  always_ff @(posedge sclk or negedge srstn) begin
    if (!srstn) begin
      last       <= 2'd3;
      fhart_hold <= '0;
    end else if (gnt_vld) begin
      last       <= gnt_id;
      fhart_hold <= gnt_id;
    end
  end

  // F->D->E->M shift; younger slots of a sleeping hart are squashed,
  // the E slot that asked to sleep still retires.
  always_ff @(posedge sclk or negedge srstn) begin
    if (!srstn) begin
      d_q <= '0;
      e_q <= '0;
      m_q <= '0;
    end else begin
      d_q <= '{hart: fhart,    vld: fvld    & ~(sleep && fhart    == e_q.hart)};
      e_q <= '{hart: d_q.hart, vld: d_q.vld & ~(sleep && d_q.hart == e_q.hart)};
      m_q <= e_q;
    end
  end

  // GPR write port: zero-fill during INIT, M-stage writeback in RUN.
  always_comb begin
    mhart = m_q.hart;
    rd0a  = wb_rda;
    rd0d  = wb_dat;
    mwre  = wb_wre & m_q.vld & (wb_rda != '0);
    if (state == INIT) begin
      mhart = cnt[6:5];
      rd0a  = cnt[4:0];
      rd0d  = '0;
      mwre  = 1'b1;
    end
  end

endmodule

// File: tb/tb_t5_hsched.sv
// Bench for t5_hsched: directed scenarios plus random traffic checked
// against a cycle-history model of the scheduler.
module tb_t5_hsched;

  logic        sclk = 1'b0;
  logic        srstn;
  logic [3:0]  hena, wak;
  logic        slp_req, wb_wre;
  logic [4:0]  wb_rda;
  logic [31:0] wb_dat;
  logic        rdy, fvld, evld, mvld, mwre;
  logic [1:0]  fhart, dhart, ehart, mhart;
  logic [4:0]  rd0a;
  logic [31:0] rd0d;

  int errors = 0;
  int checks = 0;

  t5_hsched #(.XLEN(32)) dut (
    .sclk(sclk), .srstn(srstn), .hena(hena), .wak(wak), .slp_req(slp_req),
    .wb_wre(wb_wre), .wb_rda(wb_rda), .wb_dat(wb_dat), .rdy(rdy),
    .fhart(fhart), .fvld(fvld), .dhart(dhart), .ehart(ehart), .evld(evld),
    .mhart(mhart), .mvld(mvld), .rd0a(rd0a), .rd0d(rd0d), .mwre(mwre)
  );

  always #5 sclk = ~sclk;

  // ---------------- reference model ----------------
  // hh/hv[c] record the hart fetched in cycle c since reset and whether that
  // slot is still live; D/E/M of cycle c are simply entries c-1, c-2, c-3.
  bit [1:0] hh [0:8191];
  bit       hv [0:8191];
  int       cyc;
  bit       m_init;
  int       m_cnt;
  bit [3:0] m_awake;
  int       m_last;
  bit [1:0] m_hold;

  logic       exp_rdy, exp_fvld, exp_evld, exp_mvld, exp_mwre;
  logic [1:0] exp_fhart, exp_dhart, exp_ehart, exp_mhart;
  logic [4:0] exp_rd0a;
  logic [31:0] exp_rd0d;
  logic [49:0] exp_vec;

  function automatic bit [1:0] slot_h(int i);
    return (i < 0) ? 2'd0 : hh[i];
  endfunction

  function automatic bit slot_v(int i);
    return (i < 0) ? 1'b0 : hv[i];
  endfunction

  function automatic logic [49:0] got_vec();
    return {rdy, fvld, fhart, dhart, ehart, evld, mhart, mvld, rd0a, rd0d, mwre};
  endfunction

  task automatic model_reset();
    cyc = 0; m_init = 1; m_cnt = 0; m_awake = 4'b0001; m_last = 3; m_hold = 0;
  endtask

  task automatic model_eval();
    bit found = 0;
    int w = 0;
    if (!m_init)
      for (int k = 1; k <= 4; k++) begin
        int idx = (m_last + k) % 4;
        if (!found && hena[idx] && m_awake[idx]) begin found = 1; w = idx; end
      end
    exp_fvld  = found;
    exp_fhart = found ? w[1:0] : m_hold;
    hh[cyc] = exp_fhart;
    hv[cyc] = found;
    exp_dhart = slot_h(cyc - 1);
    exp_ehart = slot_h(cyc - 2);
    exp_evld  = slot_v(cyc - 2);
    exp_mvld  = slot_v(cyc - 3);
    exp_rdy   = !m_init;
    if (m_init) begin
      {exp_mhart, exp_rd0a} = m_cnt[6:0];
      exp_rd0d = 32'd0;
      exp_mwre = 1'b1;
    end else begin
      exp_mhart = slot_h(cyc - 3);
      exp_rd0a  = wb_rda;
      exp_rd0d  = wb_dat;
      exp_mwre  = wb_wre && exp_mvld && (wb_rda != 5'd0);
    end
    exp_vec = {exp_rdy, exp_fvld, exp_fhart, exp_dhart, exp_ehart, exp_evld,
               exp_mhart, exp_mvld, exp_rd0a, exp_rd0d, exp_mwre};
  endtask

  task automatic model_adv();
    if (slp_req && slot_v(cyc - 2)) begin
      bit [1:0] h = slot_h(cyc - 2);
      if (hh[cyc] == h) hv[cyc] = 0;
      if (cyc >= 1 && hh[cyc-1] == h) hv[cyc-1] = 0;
      m_awake[h] = 1'b0;
    end
    m_awake = m_awake | wak;
    if (exp_fvld) begin m_last = exp_fhart; m_hold = exp_fhart; end
    if (m_init) begin
      if (m_cnt == 127) m_init = 0;
      m_cnt++;
    end
    cyc++;
  endtask

  task automatic eval_now();
    @(negedge sclk);
    model_eval();
  endtask

  task automatic edge_now();
    @(posedge sclk);
    if (srstn) model_adv();
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 srstn = 1'b0;
    #1 model_reset();
    model_eval();
    checks++;
    if (rdy !== 1'b0 || fvld !== 1'b0 || evld !== 1'b0 || mvld !== 1'b0) begin
      errors++;
      $display("FAIL reset_vld got rdy/f/e/m=%b%b%b%b want 0000", rdy, fvld, evld, mvld);
    end
    checks++;
    if (mwre !== 1'b1 || rd0a !== 5'd0 || mhart !== 2'd0) begin
      errors++;
      $display("FAIL reset_wport got mwre=%b rd0a=%0d mhart=%0d want 1 0 0", mwre, rd0a, mhart);
    end
    @(posedge sclk); #1;
    srstn = 1'b1;
    for (int i = 0; i < 128; i++) begin
      eval_now();
      checks++;
      if (mwre !== 1'b1 || {mhart, rd0a} !== 7'(i) || rd0d !== 32'd0 || rdy !== 1'b0) begin
        errors++;
        $display("FAIL init_clear[%0d] got mwre=%b addr=%0d d=%h rdy=%b want 1 %0d 0 0",
                 i, mwre, {mhart, rd0a}, rd0d, rdy, i);
      end
      checks++;
      if (got_vec() !== exp_vec) begin
        errors++; $display("FAIL init_vec[%0d] got=%h exp=%h", i, got_vec(), exp_vec);
      end
      edge_now();
    end
  endtask

  // First RUN cycle: wake harts 1..3 and expect strict 0,1,2,3 rotation.
  task automatic test_round_robin();
    hena = 4'hF;
    for (int k = 0; k < 12; k++) begin
      wak = (k == 0) ? 4'b1110 : 4'b0000;
      eval_now();
      if (k == 0) begin
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL rdy_rise got=%b want 1", rdy); end
      end
      checks++;
      if (fvld !== 1'b1 || fhart !== 2'(k % 4)) begin
        errors++; $display("FAIL rr_fetch[%0d] got fvld=%b fhart=%0d want 1 %0d", k, fvld, fhart, k % 4);
      end
      if (k >= 3) begin
        checks++;
        if (mvld !== 1'b1 || mhart !== 2'((k - 3) % 4)) begin
          errors++; $display("FAIL rr_mhart[%0d] got mvld=%b mhart=%0d want 1 %0d", k, mvld, mhart, (k - 3) % 4);
        end
      end
      checks++;
      if (got_vec() !== exp_vec) begin
        errors++; $display("FAIL rr_vec[%0d] got=%h exp=%h", k, got_vec(), exp_vec);
      end
      edge_now();
    end
    wak = 4'b0000;
  endtask

  task automatic test_writeback();
    logic [4:0]  rda_t [3] = '{5'd0, 5'd5, 5'd7};
    logic        wre_t [3] = '{1'b1, 1'b1, 1'b0};
    logic        mw_t  [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      wb_wre = wre_t[i]; wb_rda = rda_t[i];
      wb_dat = (i == 1) ? 32'hDEADBEEF : $urandom;
      eval_now();
      checks++;
      if (mwre !== mw_t[i]) begin
        errors++; $display("FAIL wb_mwre[%0d] got=%b want=%b", i, mwre, mw_t[i]);
      end
      if (i == 1) begin
        checks++;
        if (rd0a !== 5'd5 || rd0d !== 32'hDEADBEEF) begin
          errors++; $display("FAIL wb_data got a=%0d d=%h want 5 deadbeef", rd0a, rd0d);
        end
      end
      checks++;
      if (got_vec() !== exp_vec) begin
        errors++; $display("FAIL wb_vec[%0d] got=%h exp=%h", i, got_vec(), exp_vec);
      end
      edge_now();
    end
    wb_wre = 1'b0;
  endtask

  // Sleep and wake for hart 2 land together; hart 2 keeps its turn.
  task automatic test_same_cycle();
    bit found = 0;
    for (int n = 0; n < 8 && !found; n++) begin
      eval_now();
      checks++;
      if (got_vec() !== exp_vec) begin
        errors++; $display("FAIL same_seek_vec got=%h exp=%h", got_vec(), exp_vec);
      end
      if (exp_evld && exp_ehart == 2'd2) begin
        found = 1;
        slp_req = 1'b1; wak = 4'b0100;
        model_eval();
      end
      edge_now();
    end
    slp_req = 1'b0; wak = 4'b0000;
    checks++;
    if (!found) begin errors++; $display("FAIL same_seek timeout got=0 want=1"); end
    for (int j = 0; j < 3; j++) begin
      eval_now();
      if (j == 1) begin
        checks++;
        if (fvld !== 1'b1 || fhart !== 2'd2) begin
          errors++; $display("FAIL same_wake_wins got fvld=%b fhart=%0d want 1 2", fvld, fhart);
        end
      end
      checks++;
      if (got_vec() !== exp_vec) begin
        errors++; $display("FAIL same_vec[%0d] got=%h exp=%h", j, got_vec(), exp_vec);
      end
      edge_now();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(19) == 0) hena = 4'($urandom);
      wak     = ($urandom_range(5) == 0) ? 4'($urandom) : 4'b0000;
      slp_req = ($urandom_range(3) == 0);
      wb_wre  = 1'($urandom);
      wb_rda  = 5'($urandom);
      wb_dat  = $urandom;
      eval_now();
      checks++;
      if (got_vec() !== exp_vec) begin
        errors++; $display("FAIL rand_vec[%0d] got=%h exp=%h", n, got_vec(), exp_vec);
      end
      edge_now();
    end
    wak = 4'b0000; slp_req = 1'b0; wb_wre = 1'b0;
  endtask

  // Async reset in the middle of RUN, then a full clear pass.
  task automatic test_midreset();
    @(negedge sclk); #2;
    srstn = 1'b0;
    #1 model_reset();
    model_eval();
    checks++;
    if (rdy !== 1'b0 || fvld !== 1'b0 || evld !== 1'b0 || mvld !== 1'b0 ||
        mwre !== 1'b1 || rd0a !== 5'd0 || mhart !== 2'd0) begin
      errors++;
      $display("FAIL midreset got rdy=%b f=%b e=%b m=%b mwre=%b rd0a=%0d want 0 0 0 0 1 0",
               rdy, fvld, evld, mvld, mwre, rd0a);
    end
    @(posedge sclk); #1;
    srstn = 1'b1;
    for (int i = 0; i < 128; i++) begin
      eval_now();
      checks++;
      if (mwre !== 1'b1 || {mhart, rd0a} !== 7'(i) || got_vec() !== exp_vec) begin
        errors++; $display("FAIL reclear[%0d] got=%h exp=%h", i, got_vec(), exp_vec);
      end
      edge_now();
    end
  endtask

  // Only hart 0 awake: sleep it from E, check squash, then wake it.
  task automatic test_sleep();
    hena = 4'hF;
    for (int k = 0; k < 10; k++) begin
      slp_req = (k == 3);
      wak     = (k == 7) ? 4'b0001 : 4'b0000;
      eval_now();
      case (k)
        0, 1, 2: begin
          checks++;
          if (fvld !== 1'b1 || fhart !== 2'd0) begin
            errors++; $display("FAIL sleep_solo[%0d] got fvld=%b fhart=%0d want 1 0", k, fvld, fhart);
          end
        end
        3: begin
          checks++;
          if (evld !== 1'b1 || ehart !== 2'd0) begin
            errors++; $display("FAIL sleep_e got evld=%b ehart=%0d want 1 0", evld, ehart);
          end
        end
        4: begin
          checks++;
          if (fvld !== 1'b0 || fhart !== 2'd0 || evld !== 1'b0 || mvld !== 1'b1) begin
            errors++; $display("FAIL sleep_squash1 got f=%b fh=%0d e=%b m=%b want 0 0 0 1", fvld, fhart, evld, mvld);
          end
        end
        5: begin
          checks++;
          if (evld !== 1'b0 || mvld !== 1'b0 || fvld !== 1'b0) begin
            errors++; $display("FAIL sleep_squash2 got f=%b e=%b m=%b want 0 0 0", fvld, evld, mvld);
          end
        end
        7: begin
          checks++;
          if (fvld !== 1'b0) begin errors++; $display("FAIL wake_same_cycle got fvld=%b want 0", fvld); end
        end
        8: begin
          checks++;
          if (fvld !== 1'b1 || fhart !== 2'd0) begin
            errors++; $display("FAIL wake_issue got fvld=%b fhart=%0d want 1 0", fvld, fhart);
          end
        end
        default: ;
      endcase
      checks++;
      if (got_vec() !== exp_vec) begin
        errors++; $display("FAIL sleep_vec[%0d] got=%h exp=%h", k, got_vec(), exp_vec);
      end
      edge_now();
    end
    slp_req = 1'b0; wak = 4'b0000;
  endtask

  initial begin
    srstn = 1'b1; hena = 4'hF; wak = 4'b0000; slp_req = 1'b0;
    wb_wre = 1'b0; wb_rda = 5'd0; wb_dat = 32'd0;
    test_reset();
    test_round_robin();
    test_writeback();
    test_same_cycle();
    test_random();
    test_midreset();
    test_sleep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
